// File: rtl/fp_mac_dot_seq_if.sv
// Operand stream and fp_mac bus of the dot-product sequencer.
// slave is the sequencer side; master is the environment (operand source and the fp_mac).
interface fp_mac_dot_seq_if;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] in_a;
  logic [15:0] in_b;
  logic [15:0] mac_a;
  logic [15:0] mac_b;
  logic [31:0] mac_c;
  logic [31:0] mac_y;

  modport master (
    output in_valid, in_a, in_b, mac_y,
    input  in_ready, mac_a, mac_b, mac_c
  );

  modport slave (
    input  in_valid, in_a, in_b, mac_y,
    output in_ready, mac_a, mac_b, mac_c
  );
endinterface

// File: rtl/fp_mac_dot_seq.sv
// fp32 dot-product sequencer for a shared fp_mac (Y = A*B + C).
// Issues one MAC per operand pair and feeds each result back as C for the next pair,
// waiting out the MAC pipeline latency between dependent issues.
module fp_mac_dot_seq #(
  parameter int unsigned MAC_LAT = 3,
  parameter int unsigned LEN_W   = 8
) (
  input  logic               clock,
  input  logic               resetn,
  input  logic               start,
  input  logic [LEN_W-1:0]   len,
  input  logic [31:0]        acc_init,
  input  logic               abort,
  fp_mac_dot_seq_if.slave    bus,
  output logic               busy,
  output logic               done,
  output logic [31:0]        result
);

  localparam int unsigned CntW = (MAC_LAT > 1) ? $clog2(MAC_LAT) : 1;
  localparam logic [CntW-1:0] WaitInit = CntW'(MAC_LAT - 1);

  typedef enum logic [1:0] {StIdle, StIssue, StWait} state_e;

  state_e           state_q, state_d;
  logic [31:0]      acc_q, acc_d;
  logic [LEN_W-1:0] rem_q, rem_d;
  logic [CntW-1:0]  wait_q, wait_d;
  logic [15:0]      mac_a_q, mac_a_d;
  logic [15:0]      mac_b_q, mac_b_d;
  logic [31:0]      mac_c_q, mac_c_d;
  logic [31:0]      result_q, result_d;
  logic             done_q, done_d;
  logic             in_ready_c;

  // Next-state, datapath updates and combinational handshake/status outputs.
  always_comb begin
    state_d    = state_q;
    acc_d      = acc_q;
    rem_d      = rem_q;
    wait_d     = wait_q;
    mac_a_d    = mac_a_q;
    mac_b_d    = mac_b_q;
    mac_c_d    = mac_c_q;
    result_d   = result_q;
    done_d     = 1'b0;
    in_ready_c = 1'b0;
    busy       = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          if (len == '0) begin
            // Empty job: the initial accumulator is the answer.
            result_d = acc_init;
            done_d   = 1'b1;
          end else begin
            acc_d   = acc_init;
            rem_d   = len;
            state_d = StIssue;
          end
        end
      end
      StIssue: begin
        busy = 1'b1;
        if (abort) begin
          state_d = StIdle;
        end else begin
          in_ready_c = 1'b1;
          if (bus.in_valid) begin
            mac_a_d = bus.in_a;
            mac_b_d = bus.in_b;
            mac_c_d = acc_q;
            wait_d  = WaitInit;
            state_d = StWait;
          end
        end
      end
      StWait: begin
        busy = 1'b1;
        if (abort) begin
          state_d = StIdle;
        end else if (wait_q == '0) begin
          // mac_y now holds the result of the pair issued MAC_LAT edges ago.
          acc_d = bus.mac_y;
          rem_d = rem_q - LEN_W'(1);
          if (rem_q == LEN_W'(1)) begin
            result_d = bus.mac_y;
            done_d   = 1'b1;
            state_d  = StIdle;
          end else begin
            state_d = StIssue;
          end
        end else begin
          wait_d = wait_q - CntW'(1);
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // State and datapath registers with synchronous active-low reset.
  always_ff @(posedge clock) begin
    if (!resetn) begin
      state_q  <= StIdle;
      acc_q    <= '0;
      rem_q    <= '0;
      wait_q   <= '0;
      mac_a_q  <= '0;
      mac_b_q  <= '0;
      mac_c_q  <= '0;
      result_q <= '0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      acc_q    <= acc_d;
      rem_q    <= rem_d;
      wait_q   <= wait_d;
      mac_a_q  <= mac_a_d;
      mac_b_q  <= mac_b_d;
      mac_c_q  <= mac_c_d;
      result_q <= result_d;
      done_q   <= done_d;
    end
  end

  assign bus.in_ready = in_ready_c;
  assign bus.mac_a    = mac_a_q;
  assign bus.mac_b    = mac_b_q;
  assign bus.mac_c    = mac_c_q;
  assign done         = done_q;
  assign result       = result_q;

endmodule

// File: tb/tb_fp_mac_dot_seq.sv
// Bench for fp_mac_dot_seq: table-driven jobs, hand-written abort/reset/back-to-back
// sequences and random jobs against a sequential dot-product fold.
module tb_fp_mac_dot_seq;
  localparam int unsigned MAC_LAT  = 3;
  localparam int unsigned LEN_W    = 8;
  localparam int unsigned MaxPairs = 8;

  typedef logic [MaxPairs-1:0][15:0] pairs_t;

  typedef struct {
    int          n;
    logic [31:0] acc;
    pairs_t      a;
    pairs_t      b;
    int          gap;
    logic [31:0] exp;
  } vec_t;

  logic             clock = 1'b0;
  logic             resetn = 1'b0;
  logic             start = 1'b0;
  logic             abort = 1'b0;
  logic [LEN_W-1:0] len = '0;
  logic [31:0]      acc_init = '0;
  logic             busy;
  logic             done;
  logic [31:0]      result;

  fp_mac_dot_seq_if bus ();

  fp_mac_dot_seq #(.MAC_LAT(MAC_LAT), .LEN_W(LEN_W)) dut (
    .clock    (clock),
    .resetn   (resetn),
    .start    (start),
    .len      (len),
    .acc_init (acc_init),
    .abort    (abort),
    .bus      (bus),
    .busy     (busy),
    .done     (done),
    .result   (result)
  );

  always #5 clock = ~clock;

  int unsigned cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  // fp values as reals; denormals flushed to zero, conversion back truncates.
  function automatic real h2r(input logic [15:0] h);
    logic [10:0] e;
    if (h[14:10] == 5'd0) return 0.0;
    e = 11'(h[14:10]) + 11'd1008;
    return $bitstoreal({h[15], e, h[9:0], 42'd0});
  endfunction

  function automatic real f2r(input logic [31:0] f);
    logic [10:0] e;
    if (f[30:23] == 8'd0) return 0.0;
    e = 11'(f[30:23]) + 11'd896;
    return $bitstoreal({f[31], e, f[22:0], 29'd0});
  endfunction

  function automatic logic [31:0] r2f(input real r);
    logic [63:0] d;
    logic [10:0] e;
    d = $realtobits(r);
    if (d[62:52] == 11'd0) return {d[63], 31'd0};
    e = d[62:52] - 11'd896;
    return {d[63], e[7:0], d[51:29]};
  endfunction

  function automatic logic [31:0] mac_f(input logic [15:0] a, input logic [15:0] b,
                                        input logic [31:0] c);
    return r2f(h2r(a) * h2r(b) + f2r(c));
  endfunction

  function automatic logic [31:0] dot_ref(input int n, input logic [31:0] acc,
                                          input pairs_t a, input pairs_t b);
    logic [31:0] s;
    s = acc;
    for (int i = 0; i < n; i++) s = mac_f(a[i], b[i], s);
    return s;
  endfunction

  // fp_mac stand-in: result visible MAC_LAT edges after its inputs change.
  logic [31:0] pipe [MAC_LAT-1];
  always @(posedge clock) begin
    pipe[0] <= mac_f(bus.mac_a, bus.mac_b, bus.mac_c);
    for (int k = 1; k < MAC_LAT - 1; k++) pipe[k] <= pipe[k-1];
  end
  assign bus.mac_y = pipe[MAC_LAT-2];

  int n_checks = 0;
  int n_fail   = 0;
  logic [31:0] last_exp = '0;
  logic [15:0] last_ma = '0;
  logic [15:0] last_mb = '0;
  logic [31:0] last_mc = '0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic wait_ready(output bit ok);
    int t = 0;
    while (!bus.in_ready && t < 50) begin
      @(negedge clock);
      t++;
    end
    ok = bus.in_ready;
  endtask

  // Starts a job at the current negedge and returns at the negedge where done is seen.
  task automatic run_job(input int n, input logic [31:0] acc, input pairs_t a, input pairs_t b,
                         input int gap, input bit poke, input logic [31:0] exp,
                         input string name);
    int unsigned e0;
    int unsigned exp_cyc;
    logic [31:0] racc;
    bit ok;
    int t;
    start    = 1'b1;
    len      = LEN_W'(n);
    acc_init = acc;
    @(negedge clock);
    start = 1'b0;
    e0    = cyc;
    racc  = acc;
    if (n == 0) begin
      chk({name, " zero-len done"}, 32'(done), 32'd1);
      chk({name, " zero-len in_ready"}, 32'(bus.in_ready), 32'd0);
      chk({name, " zero-len result"}, result, exp);
      chk({name, " zero-len mac_a"}, 32'(bus.mac_a), 32'(last_ma));
      chk({name, " zero-len mac_b"}, 32'(bus.mac_b), 32'(last_mb));
      chk({name, " zero-len mac_c"}, bus.mac_c, last_mc);
      last_exp = exp;
      return;
    end
    chk({name, " busy after start"}, 32'(busy), 32'd1);
    chk({name, " done after start"}, 32'(done), 32'd0);
    for (int i = 0; i < n; i++) begin
      if (i == 1 && gap > 0) begin
        bus.in_valid = 1'b0;
        wait_ready(ok);
        repeat (gap) begin
          chk({name, " in_ready in gap"}, 32'(bus.in_ready), 32'd1);
          @(negedge clock);
        end
      end
      bus.in_valid = 1'b1;
      bus.in_a     = a[i];
      bus.in_b     = b[i];
      wait_ready(ok);
      if (!ok) begin
        chk({name, " handshake timeout"}, 32'd0, 32'd1);
        bus.in_valid = 1'b0;
        return;
      end
      @(negedge clock);
      chk($sformatf("%s mac_a pair %0d", name, i), 32'(bus.mac_a), 32'(a[i]));
      chk($sformatf("%s mac_b pair %0d", name, i), 32'(bus.mac_b), 32'(b[i]));
      chk($sformatf("%s mac_c pair %0d", name, i), bus.mac_c, racc);
      last_ma = a[i];
      last_mb = b[i];
      last_mc = racc;
      racc    = mac_f(a[i], b[i], racc);
      if (poke && i == 0) begin
        // start while busy must not disturb the running job
        start    = 1'b1;
        len      = LEN_W'(7);
        acc_init = 32'hdeadbeef;
        @(negedge clock);
        start = 1'b0;
      end
    end
    bus.in_valid = 1'b0;
    t = 0;
    while (!done && t < 100) begin
      @(negedge clock);
      t++;
    end
    exp_cyc = e0 + n * (MAC_LAT + 1) + ((n > 1) ? gap : 0);
    chk({name, " done seen"}, 32'(done), 32'd1);
    chk({name, " done cycle"}, cyc, exp_cyc);
    chk({name, " busy at done"}, 32'(busy), 32'd0);
    chk({name, " in_ready at done"}, 32'(bus.in_ready), 32'd0);
    chk({name, " result"}, result, exp);
    last_exp = exp;
  endtask

  task automatic idle_check(input string name);
    @(negedge clock);
    chk({name, " done single cycle"}, 32'(done), 32'd0);
    chk({name, " idle busy"}, 32'(busy), 32'd0);
  endtask

  vec_t   vecs [5];
  pairs_t pa, pb;

  initial begin
    bus.in_valid = 1'b0;
    bus.in_a     = '0;
    bus.in_b     = '0;

    vecs[0] = '{n: 2, acc: 32'h0, a: '0, b: '0, gap: 0, exp: 32'h40600000};
    vecs[0].a[0] = 16'h3C00; vecs[0].b[0] = 16'h4000;
    vecs[0].a[1] = 16'h4200; vecs[0].b[1] = 16'h3800;
    vecs[1] = '{n: 0, acc: 32'h3F800000, a: '0, b: '0, gap: 0, exp: 32'h3F800000};
    vecs[2] = '{n: 3, acc: 32'h3F800000, a: '0, b: '0, gap: 5, exp: 32'h40800000};
    for (int i = 0; i < 3; i++) begin
      vecs[2].a[i] = 16'h3C00;
      vecs[2].b[i] = 16'h3C00;
    end
    vecs[3] = '{n: 1, acc: 32'h0, a: '0, b: '0, gap: 0, exp: 32'h40800000};
    vecs[3].a[0] = 16'h4000; vecs[3].b[0] = 16'h4000;
    // 2 + 4 - 1 + 0.25 + 4 = 9.25
    vecs[4] = '{n: 4, acc: 32'h40000000, a: '0, b: '0, gap: 2, exp: 32'h41140000};
    vecs[4].a[0] = 16'h4000; vecs[4].b[0] = 16'h4000;
    vecs[4].a[1] = 16'hBC00; vecs[4].b[1] = 16'h3C00;
    vecs[4].a[2] = 16'h3800; vecs[4].b[2] = 16'h3800;
    vecs[4].a[3] = 16'h4400; vecs[4].b[3] = 16'h3C00;

    // Reset state
    repeat (2) @(negedge clock);
    chk("reset in_ready", 32'(bus.in_ready), 32'd0);
    chk("reset busy", 32'(busy), 32'd0);
    chk("reset done", 32'(done), 32'd0);
    chk("reset mac_a", 32'(bus.mac_a), 32'd0);
    chk("reset mac_c", bus.mac_c, 32'd0);
    chk("reset result", result, 32'd0);
    resetn = 1'b1;
    @(negedge clock);

    for (int v = 0; v < 5; v++) begin
      run_job(vecs[v].n, vecs[v].acc, vecs[v].a, vecs[v].b, vecs[v].gap, 1'b0, vecs[v].exp,
              $sformatf("vec%0d", v));
      idle_check($sformatf("vec%0d", v));
      repeat (2) @(negedge clock);
    end

    // Abort in the second WAIT of a 4-pair job
    start = 1'b1; len = LEN_W'(4); acc_init = 32'h0;
    bus.in_valid = 1'b1; bus.in_a = 16'h3C00; bus.in_b = 16'h3C00;
    @(negedge clock);
    start = 1'b0;
    for (int i = 0; i < 2; i++) begin
      bit ok;
      wait_ready(ok);
      chk("abort job handshake", 32'(ok), 32'd1);
      @(negedge clock);
      last_ma = 16'h3C00; last_mb = 16'h3C00;
    end
    bus.in_valid = 1'b0;
    abort = 1'b1;
    @(negedge clock);
    abort = 1'b0;
    chk("abort busy", 32'(busy), 32'd0);
    chk("abort in_ready", 32'(bus.in_ready), 32'd0);
    chk("abort done", 32'(done), 32'd0);
    chk("abort result held", result, last_exp);
    bus.in_valid = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clock);
      chk("after abort no done", 32'(done), 32'd0);
      chk("after abort in_ready", 32'(bus.in_ready), 32'd0);
    end
    bus.in_valid = 1'b0;
    pa = '0; pb = '0; pa[0] = 16'h4000; pb[0] = 16'h4000;
    run_job(1, 32'h0, pa, pb, 0, 1'b0, 32'h40800000, "after abort");
    idle_check("after abort");

    // Abort in ISSUE: in_ready forced low, no handshake
    start = 1'b1; len = LEN_W'(2); acc_init = 32'h0;
    @(negedge clock);
    start = 1'b0;
    bus.in_valid = 1'b1; bus.in_a = 16'h1234; bus.in_b = 16'h5678;
    abort = 1'b1;
    #1;
    chk("abort issue in_ready", 32'(bus.in_ready), 32'd0);
    @(negedge clock);
    abort = 1'b0; bus.in_valid = 1'b0;
    chk("abort issue busy", 32'(busy), 32'd0);
    chk("abort issue mac_a", 32'(bus.mac_a), 32'(last_ma));

    // Reset during ISSUE
    start = 1'b1; len = LEN_W'(2); acc_init = 32'h3F800000;
    bus.in_valid = 1'b1; bus.in_a = 16'h4000; bus.in_b = 16'h4000;
    @(negedge clock);
    start = 1'b0;
    resetn = 1'b0;
    @(negedge clock);
    resetn = 1'b1; bus.in_valid = 1'b0;
    chk("midjob reset in_ready", 32'(bus.in_ready), 32'd0);
    chk("midjob reset busy", 32'(busy), 32'd0);
    chk("midjob reset done", 32'(done), 32'd0);
    chk("midjob reset mac_a", 32'(bus.mac_a), 32'd0);
    chk("midjob reset mac_b", 32'(bus.mac_b), 32'd0);
    chk("midjob reset mac_c", bus.mac_c, 32'd0);
    chk("midjob reset result", result, 32'd0);
    last_exp = '0; last_ma = '0; last_mb = '0; last_mc = '0;
    repeat (5) begin
      @(negedge clock);
      chk("after reset no done", 32'(done), 32'd0);
    end
    // 3 + 2 + 1 = 6, with a start poked while busy
    pa = '0; pb = '0;
    pa[0] = 16'h4000; pb[0] = 16'h3C00;
    pa[1] = 16'h3C00; pb[1] = 16'h3C00;
    run_job(2, 32'h40400000, pa, pb, 0, 1'b1, 32'h40C00000, "poke");
    idle_check("poke");

    // Back-to-back: each start lands in the previous done cycle
    pa = '0; pb = '0; pa[0] = 16'h4200; pb[0] = 16'h4200;
    run_job(1, 32'h0, pa, pb, 0, 1'b0, 32'h41100000, "b2b1");
    pa = '0; pb = '0;
    pa[0] = 16'h3C00; pb[0] = 16'hBC00;
    pa[1] = 16'h3800; pb[1] = 16'h4000;
    run_job(2, 32'h40A00000, pa, pb, 0, 1'b0, 32'h40A00000, "b2b2");
    run_job(0, 32'h12345678, pa, pb, 0, 1'b0, 32'h12345678, "b2b3");
    idle_check("b2b3");

    // Random jobs against the fold model
    for (int r = 0; r < 10; r++) begin
      int n;
      int gap;
      logic [31:0] acc;
      n   = int'($urandom_range(1, 6));
      gap = int'($urandom_range(0, 3));
      acc = {1'($urandom), 8'($urandom_range(120, 134)), 23'($urandom)};
      pa = '0; pb = '0;
      for (int i = 0; i < n; i++) begin
        pa[i] = {1'($urandom), 5'($urandom_range(10, 20)), 10'($urandom)};
        pb[i] = {1'($urandom), 5'($urandom_range(10, 20)), 10'($urandom)};
      end
      run_job(n, acc, pa, pb, gap, 1'($urandom), dot_ref(n, acc, pa, pb),
              $sformatf("rand%0d", r));
      if ($urandom_range(0, 1) == 1) idle_check($sformatf("rand%0d", r));
    end
    idle_check("final");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL global timeout: simulation did not complete, expected finish");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/fp_mac_dot_seq.md
Name: fp_mac_dot_seq

Overview:
Sequencer that computes an fp32 dot product on the shared fp_mac unit (Y = A*B + C, with A and B fp16 and C and Y fp32). It accepts a job of `len` fp16 operand pairs over a valid/ready stream. It issues one MAC per pair and feeds each result back as C for the next pair. It reports the final fp32 sum with a one-cycle done pulse. It sits between the operand-fetch logic and a single fp_mac instance, and serialises the accumulation dependency across the MAC pipeline latency.

Parameters:
MAC_LAT, 3, clock edges from the edge that updates mac_a/mac_b/mac_c to the edge at which mac_y holds the matching result (must be >= 1).
LEN_W, 8, width of the job length field.

Ports:
clock  in  1  system clock, rising edge.
resetn  in  1  synchronous active-low reset.
start  in  1  job start, sampled only in IDLE.
len  in  LEN_W  number of operand pairs, sampled with start.
acc_init  in  32  fp32 initial accumulator, sampled with start.
abort  in  1  synchronous job cancel.
in_valid  in  1  operand pair valid.
in_ready  out  1  sequencer accepts pair this cycle.
in_a  in  16  fp16 operand A.
in_b  in  16  fp16 operand B.
mac_a  out  16  to fp_mac A.
mac_b  out  16  to fp_mac B.
mac_c  out  32  to fp_mac C.
mac_y  in  32  from fp_mac Y.
busy  out  1  job in progress.
done  out  1  one-cycle pulse: result valid.
result  out  32  final fp32 sum, held until next done.

Behaviour:
- Reset: resetn is sampled low at a rising edge. The FSM goes to IDLE and the counters clear. in_ready, busy, done, mac_a, mac_b, mac_c and result are all 0. Reset has priority over abort and start.
- FSM states: IDLE, ISSUE, WAIT.
- IDLE:
  - in_ready = 0, busy = 0.
  - start = 1 with len = 0: stay in IDLE, result <= acc_init, done = 1 for one cycle.
  - start = 1 with len > 0: acc <= acc_init, remaining <= len, go to ISSUE.
- ISSUE:
  - busy = 1; in_ready = 1 combinationally.
  - Handshake is in_valid & in_ready at an edge. On that edge: mac_a <= in_a, mac_b <= in_b, mac_c <= acc, wait counter <= MAC_LAT-1, go to WAIT.
  - Without in_valid, hold in ISSUE; there is no timeout.
- WAIT:
  - busy = 1, in_ready = 0.
  - mac_a, mac_b and mac_c are held stable. Repeated sampling by the fp_mac is harmless.
  - The counter decrements each edge. At the edge where the counter is 0 (the MAC_LAT-th edge after issue): acc <= mac_y, remaining decrements.
  - If remaining was 1 at that edge: result <= mac_y, done pulses, go to IDLE.
  - Otherwise go to ISSUE.
- Timing: take E0 as the start edge and continuous in_valid.
  - Pair i (0-based) handshakes at E0+1+i*(MAC_LAT+1).
  - Its result is captured at E0+(i+1)*(MAC_LAT+1).
  - done is high in the cycle after E0+len*(MAC_LAT+1).
- done:
  - Registered, exactly one cycle per job, never asserted on abort.
  - A start in the same cycle as done is accepted, because the FSM is already in IDLE.
- start while busy: ignored; len and acc_init are not resampled.
- abort = 1 at an edge in ISSUE or WAIT: go to IDLE, no handshake that edge (in_ready forced 0), result unchanged, no done. abort in IDLE: no effect.
- No arithmetic in the block: the fp32 values are passed through bit-exact. Rounding and special values (NaN, Inf, denormal) are the fp_mac's responsibility.
- Maximum job length is 2^LEN_W-1 pairs. The counters do not wrap within a job.

Test Plan:
1. Two-pair dot product. acc_init = 0x00000000, len = 2, pairs (0x3C00, 0x4000) then (0x4200, 0x3800), continuous valid, MAC_LAT = 3 -> result = 0x40600000 (3.5), done high exactly in the cycle after E0+8, busy low in that same cycle.
2. Zero-length job. start with len = 0, acc_init = 0x3F800000 -> done in the cycle after E0, result = 0x3F800000, in_ready never high, mac_* unchanged.
3. Backpressure. len = 3, all pairs (0x3C00, 0x3C00), acc_init = 0x3F800000, in_valid low for 5 cycles before the second pair -> in_ready stays high through the gap, result = 0x40800000 (4.0), done at E0+12+5.
4. Abort. len = 4, assert abort in the second WAIT -> FSM IDLE next cycle, no done, result keeps its previous value. A new start with len = 1, pair (0x4000, 0x4000), acc_init = 0 then gives result = 0x40800000.
5. Reset mid-job. resetn low for one edge during ISSUE -> all outputs 0 next cycle, no done. A start issued during busy of a following job is ignored (busy and len unchanged).
6. Back-to-back. start asserted in the done cycle of job 1 -> job 2 accepted. Results of both jobs are correct and each done is a single cycle.
